// File: rtl/rv_pkg.sv
// Shared RISC-V register-file constants, types and the per-register mask helper.
// Consumed by reg_file_sb, rf_scoreboard and reg_file_sb_if.
package rv_pkg;

   localparam int XLEN       = 32;
   localparam int NUM_REGS   = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [REG_ADDR_W-1:0] X0_IDX = '0;

   typedef logic [XLEN-1:0]       xword_t;
   typedef logic [REG_ADDR_W-1:0] raddr_t;
   typedef logic [NUM_REGS-1:0]   busy_t;

   // One-hot mask for a register; x0 never produces a bit because it can never be pending.
   function automatic busy_t regMask(input logic en, input raddr_t addr);
      busy_t m;
      m = '0;
      if (en && (addr != X0_IDX)) begin
         m[addr] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback/flush bundle between the pipeline (master) and the register file (slave).
interface reg_file_sb_if;
   import rv_pkg::*;

   raddr_t rs1_addr;
   raddr_t rs2_addr;
   xword_t rs1_data;
   xword_t rs2_data;
   logic   wb_write_en;
   raddr_t wb_write_addr;
   xword_t wb_write_data;
   logic   issue_en;
   raddr_t issue_rd;
   logic   squash_en;
   raddr_t squash_rd;
   logic   rs1_busy;
   logic   rs2_busy;
   busy_t  busy_vec;

   modport master (
      output rs1_addr, rs2_addr,
      output wb_write_en, wb_write_addr, wb_write_data,
      output issue_en, issue_rd, squash_en, squash_rd,
      input  rs1_data, rs2_data, rs1_busy, rs2_busy, busy_vec
   );

   modport slave (
      input  rs1_addr, rs2_addr,
      input  wb_write_en, wb_write_addr, wb_write_data,
      input  issue_en, issue_rd, squash_en, squash_rd,
      output rs1_data, rs2_data, rs1_busy, rs2_busy, busy_vec
   );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: issue sets a register's busy bit; writeback or squash clears it.
// When a set and a clear hit the same register in one cycle, the set wins.
module rf_scoreboard
   import rv_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   issue_en_i,
   input  raddr_t issue_rd_i,
   input  logic   wb_write_en_i,
   input  raddr_t wb_write_addr_i,
   input  logic   squash_en_i,
   input  raddr_t squash_rd_i,
   input  raddr_t rs1_addr_i,
   input  raddr_t rs2_addr_i,
   output logic   rs1_busy_o,
   output logic   rs2_busy_o,
   output busy_t  busy_vec_o
);

   busy_t busy_q;
   busy_t busy_d;
   busy_t setMask;
   busy_t clrMask;

   // Clears are applied first so a same-register issue overrides the older retirement.
   always_comb begin
      setMask         = regMask(issue_en_i, issue_rd_i);
      clrMask         = regMask(wb_write_en_i, wb_write_addr_i)
                      | regMask(squash_en_i, squash_rd_i);
      busy_d          = (busy_q & ~clrMask) | setMask;
      busy_d[X0_IDX]  = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign rs1_busy_o = (rs1_addr_i == X0_IDX) ? 1'b0 : busy_q[rs1_addr_i];
   assign rs2_busy_o = (rs2_addr_i == X0_IDX) ? 1'b0 : busy_q[rs2_addr_i];
   assign busy_vec_o = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file (x0 hard-wired to zero) with pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module reg_file_sb #(
   parameter int XLEN     = rv_pkg::XLEN,
   parameter int NUM_REGS = rv_pkg::NUM_REGS
) (
   input logic         clk,
   input logic         rst_n,
   reg_file_sb_if.slave bus
);
   import rv_pkg::X0_IDX;

   logic [XLEN-1:0] regs_q [NUM_REGS];
   logic [XLEN-1:0] regs_d [NUM_REGS];
   logic            wrHit;
   logic [XLEN-1:0] rs1Raw;
   logic [XLEN-1:0] rs2Raw;
   logic            sb1Busy;
   logic            sb2Busy;

   always_comb begin
      wrHit  = bus.wb_write_en && (bus.wb_write_addr != X0_IDX);
      regs_d = regs_q;
      if (wrHit) begin
         regs_d[bus.wb_write_addr] = bus.wb_write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rs1Raw = (bus.rs1_addr == X0_IDX) ? '0 : regs_q[bus.rs1_addr];
   assign rs2Raw = (bus.rs2_addr == X0_IDX) ? '0 : regs_q[bus.rs2_addr];

   rf_scoreboard u_sb (
      .clk             (clk),
      .rst_n           (rst_n),
      .issue_en_i      (bus.issue_en),
      .issue_rd_i      (bus.issue_rd),
      .wb_write_en_i   (bus.wb_write_en),
      .wb_write_addr_i (bus.wb_write_addr),
      .squash_en_i     (bus.squash_en),
      .squash_rd_i     (bus.squash_rd),
      .rs1_addr_i      (bus.rs1_addr),
      .rs2_addr_i      (bus.rs2_addr),
      .rs1_busy_o      (sb1Busy),
      .rs2_busy_o      (sb2Busy),
      .busy_vec_o      (bus.busy_vec)
   );

`ifdef REGFILE_BYPASS_EN
   // A forwarded operand is already available, so it must not stall decode.
   logic byp1;
   logic byp2;
   assign byp1         = wrHit && (bus.wb_write_addr == bus.rs1_addr);
   assign byp2         = wrHit && (bus.wb_write_addr == bus.rs2_addr);
   assign bus.rs1_data = byp1 ? bus.wb_write_data : rs1Raw;
   assign bus.rs2_data = byp2 ? bus.wb_write_data : rs2Raw;
   assign bus.rs1_busy = sb1Busy & ~byp1;
   assign bus.rs2_busy = sb2Busy & ~byp2;
`else
   assign bus.rs1_data = rs1Raw;
   assign bus.rs2_data = rs2Raw;
   assign bus.rs1_busy = sb1Busy;
   assign bus.rs2_busy = sb2Busy;
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard-style bench for reg_file_sb: stimulus pushes expected read-port values, a monitor pops and compares.
module tb_reg_file_sb;
   import rv_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   reg_file_sb_if bus ();

   reg_file_sb #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int          cyc;
      logic [31:0] rs1Data;
      logic [31:0] rs2Data;
      logic        rs1Busy;
      logic        rs2Busy;
      logic [31:0] busyVec;
   } exp_t;

   exp_t        expQ[$];
   int          checks  = 0;
   int          errors  = 0;
   int          cycleNo = 0;
   logic [31:0] model [32];
   bit          pend  [32];

   task automatic compare(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic bit bypassHit(input int a, input bit wbEn, input int wbA);
      bit hit;
      hit = 1'b0;
`ifdef REGFILE_BYPASS_EN
      hit = wbEn && (wbA != 0) && (wbA == a);
`endif
      return hit;
   endfunction

   function automatic logic [31:0] readModel(input int a, input bit byp, input logic [31:0] wbD);
      if (a == 0) return 32'h0;
      if (byp) return wbD;
      return model[a];
   endfunction

   // Expected outputs come from state before this edge; model state then advances.
   task automatic applyStimulus(input bit rstN, input int a1, input int a2,
                                input bit wbEn, input int wbA, input logic [31:0] wbD,
                                input bit iss, input int issRd, input bit sq, input int sqRd);
      exp_t e;
      bit   b1;
      bit   b2;
      @(posedge clk);
      #1;
      rst_n             = rstN;
      bus.rs1_addr      = raddr_t'(a1);
      bus.rs2_addr      = raddr_t'(a2);
      bus.wb_write_en   = wbEn;
      bus.wb_write_addr = raddr_t'(wbA);
      bus.wb_write_data = wbD;
      bus.issue_en      = iss;
      bus.issue_rd      = raddr_t'(issRd);
      bus.squash_en     = sq;
      bus.squash_rd     = raddr_t'(sqRd);
      cycleNo++;
      b1        = bypassHit(a1, wbEn, wbA);
      b2        = bypassHit(a2, wbEn, wbA);
      e.cyc     = cycleNo;
      e.rs1Data = readModel(a1, b1, wbD);
      e.rs2Data = readModel(a2, b2, wbD);
      e.rs1Busy = (a1 != 0) && pend[a1] && !b1;
      e.rs2Busy = (a2 != 0) && pend[a2] && !b2;
      for (int i = 0; i < 32; i++) e.busyVec[i] = pend[i];
      expQ.push_back(e);
      if (!rstN) begin
         for (int i = 0; i < 32; i++) begin
            model[i] = 32'h0;
            pend[i]  = 1'b0;
         end
      end else begin
         if (wbEn && wbA != 0) begin
            model[wbA] = wbD;
            pend[wbA]  = 1'b0;
         end
         if (sq && sqRd != 0) pend[sqRd] = 1'b0;
         if (iss && issRd != 0) pend[issRd] = 1'b1;
      end
   endtask

   task automatic idle(input int a1, input int a2);
      applyStimulus(1'b1, a1, a2, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0, 0);
   endtask

   task automatic checkOutput(input exp_t e);
      compare("rs1_data", e.cyc, bus.rs1_data, e.rs1Data);
      compare("rs2_data", e.cyc, bus.rs2_data, e.rs2Data);
      compare("rs1_busy", e.cyc, {31'h0, bus.rs1_busy}, {31'h0, e.rs1Busy});
      compare("rs2_busy", e.cyc, {31'h0, bus.rs2_busy}, {31'h0, e.rs2Busy});
      compare("busy_vec", e.cyc, bus.busy_vec, e.busyVec);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin : stimulus
      rst_n             = 1'b0;
      bus.rs1_addr      = '0;
      bus.rs2_addr      = '0;
      bus.wb_write_en   = 1'b0;
      bus.wb_write_addr = '0;
      bus.wb_write_data = '0;
      bus.issue_en      = 1'b0;
      bus.issue_rd      = '0;
      bus.squash_en     = 1'b0;
      bus.squash_rd     = '0;
      for (int i = 0; i < 32; i++) begin
         model[i] = 32'h0;
         pend[i]  = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Post-reset sweep of every register through both ports.
      for (int a = 1; a < 32; a++) idle(a, 32 - a);

      // x5 write/readback, then an attempted x0 write.
      applyStimulus(1'b1, 5, 0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 1'b0, 0);
      idle(5, 0);
      applyStimulus(1'b1, 0, 5, 1'b1, 0, 32'h00001234, 1'b0, 0, 1'b0, 0);
      idle(0, 0);

      // Issue x7, observe busy, write it back.
      applyStimulus(1'b1, 0, 7, 1'b0, 0, 32'h0, 1'b1, 7, 1'b0, 0);
      idle(0, 7);
      applyStimulus(1'b1, 0, 7, 1'b1, 7, 32'h00000055, 1'b0, 0, 1'b0, 0);
      idle(0, 7);

      // Same-cycle set and clear of x9, then a squash.
      applyStimulus(1'b1, 9, 0, 1'b0, 0, 32'h0, 1'b1, 9, 1'b0, 0);
      applyStimulus(1'b1, 9, 9, 1'b1, 9, 32'h99990000, 1'b1, 9, 1'b0, 0);
      idle(9, 9);
      applyStimulus(1'b1, 9, 0, 1'b0, 0, 32'h0, 1'b0, 0, 1'b1, 9);
      idle(9, 9);

      // Write x3 while reading it with a pending issue.
      applyStimulus(1'b1, 0, 0, 1'b1, 3, 32'h11111111, 1'b0, 0, 1'b0, 0);
      applyStimulus(1'b1, 3, 0, 1'b0, 0, 32'h0, 1'b1, 3, 1'b0, 0);
      applyStimulus(1'b1, 3, 3, 1'b1, 3, 32'hA5A5A5A5, 1'b0, 0, 1'b0, 0);
      idle(3, 0);

      // Mid-operation reset discards busy state and data.
      applyStimulus(1'b1, 0, 0, 1'b1, 4, 32'h0000CAFE, 1'b1, 6, 1'b0, 0);
      applyStimulus(1'b1, 4, 6, 1'b0, 0, 32'h0, 1'b1, 4, 1'b0, 0);
      applyStimulus(1'b0, 4, 6, 1'b1, 6, 32'h12345678, 1'b1, 8, 1'b1, 4);
      idle(4, 6);

      for (int n = 0; n < 800; n++) begin
         applyStimulus($urandom_range(0, 49) != 0,
                       int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                       $urandom_range(0, 9) < 4, int'($urandom_range(0, 31)), $urandom,
                       $urandom_range(0, 9) < 4, int'($urandom_range(0, 31)),
                       $urandom_range(0, 9) < 2, int'($urandom_range(0, 31)));
      end

      @(negedge clk);
      #1;
      compare("queue_drain", cycleNo, 32'(expQ.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
